rv_stage_buffer: RTL and testbench

Parametrised elastic pipeline buffer between stages of the RV32I pipeline, e.g. fetch→decode or decode→execute. Generalises the fixed single-entry stage register into a DEPTH-entry FIFO with a valid/ready handshake on both sides, synchronous flush for branch/jump redirect, and an occupancy count. The payload is an opaque WIDTH-bit vector, normally a packed `stage_regs` value from `rv32i_types`.

---
 rtl/rv_stage_buffer.sv | 61 ++++++
 tb/tb_rv_stage_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_stage_buffer.sv
// Elastic DEPTH-entry buffer between RV32I pipeline stages.
// Valid/ready on both sides, synchronous flush, occupancy count.
module rv_stage_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    // Ready/valid come from registered count only, never from out_ready.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_stage_buffer.sv
// Directed bench for rv_stage_buffer at DEPTH=4 and DEPTH=2,
// closing with a queue-model random run on the DEPTH=4 instance.
module tb_rv_stage_buffer;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [2:0]  count;

    logic        rst2, flush2, in_valid2, out_ready2;
    logic [31:0] in_data2;
    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_stage_buffer #(.WIDTH(32), .DEPTH(4)) u (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count)
    );

    rv_stage_buffer #(.WIDTH(32), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst2), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .count(count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] s[3];
        bit          p_push, p_pop;

        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        rst2 = 1; flush2 = 0; in_valid2 = 0; out_ready2 = 0; in_data2 = '0;
        tick();
        tick();
        rst = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_iready", 32'(in_ready), 1);

        // Stream 0x11,0x22,0x33 with out_ready high
        s[0] = 32'h11; s[1] = 32'h22; s[2] = 32'h33;
        out_ready = 1;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = s[i];
            tick();
            chk("stream_data", out_data, s[i]);
            chk("stream_count", 32'(count), 1);
        end
        in_valid = 0;
        tick();
        chk("stream_empty", 32'(out_valid), 0);

        // Fill and backpressure
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA0 + 32'(i);
            tick();
        end
        chk("fill_count", 32'(count), 4);
        chk("fill_iready", 32'(in_ready), 0);
        in_data = 32'hA4;
        tick();
        chk("full_refuse_count", 32'(count), 4);
        chk("full_head", out_data, 32'hA0);
        out_ready = 1;
        tick();
        chk("pop1_count", 32'(count), 3);
        chk("pop1_iready", 32'(in_ready), 1);
        chk("pop1_data", out_data, 32'hA1);
        tick();
        in_valid = 0;
        chk("pushA4_count", 32'(count), 3);
        chk("drain_A2", out_data, 32'hA2);
        tick();
        chk("drain_A3", out_data, 32'hA3);
        tick();
        chk("drain_A4", out_data, 32'hA4);
        tick();
        chk("drain_empty", 32'(count), 0);

        // Simultaneous push/pop at count=2, pointers wrap
        out_ready = 0;
        in_valid = 1;
        in_data = 32'hB0;
        tick();
        in_data = 32'hB1;
        tick();
        chk("pp_start", 32'(count), 2);
        out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            in_data = 32'hB2 + 32'(k);
            tick();
            chk("pp_count", 32'(count), 2);
            chk("pp_data", out_data, 32'hB1 + 32'(k));
        end
        in_valid = 0;
        tick();
        chk("pp_tail", out_data, 32'hB7);
        tick();
        chk("pp_empty", 32'(count), 0);

        // Flush with concurrent push
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hC0 + 32'(i);
            tick();
        end
        chk("fl_pre", 32'(count), 3);
        flush = 1; in_data = 32'hFF; out_ready = 1;
        tick();
        chk("fl_count", 32'(count), 0);
        chk("fl_ovalid", 32'(out_valid), 0);
        chk("fl_iready", 32'(in_ready), 1);
        flush = 0; in_data = 32'h55; out_ready = 0;
        tick();
        chk("fl_next_count", 32'(count), 1);
        chk("fl_next_data", out_data, 32'h55);
        in_valid = 0; out_ready = 1;
        tick();
        chk("fl_drained", 32'(count), 0);

        // Reset mid-stream with push and pop
        out_ready = 0;
        in_valid = 1;
        in_data = 32'hD0;
        tick();
        in_data = 32'hD1;
        tick();
        chk("mr_pre", 32'(count), 2);
        rst = 1; in_data = 32'hD2; out_ready = 1;
        tick();
        chk("mr_count", 32'(count), 0);
        chk("mr_ovalid", 32'(out_valid), 0);
        chk("mr_iready", 32'(in_ready), 1);
        rst = 0; in_data = 32'hE0; out_ready = 0;
        tick();
        chk("mr_next_count", 32'(count), 1);
        chk("mr_next_data", out_data, 32'hE0);
        in_valid = 0; out_ready = 1;
        tick();

        // DEPTH=2 fill and backpressure
        rst2 = 0;
        in_valid2 = 1;
        in_data2 = 32'h1;
        tick();
        in_data2 = 32'h2;
        tick();
        chk("d2_full", 32'(count2), 2);
        chk("d2_iready", 32'(in_ready2), 0);
        in_data2 = 32'h3;
        tick();
        chk("d2_refuse", 32'(count2), 2);
        chk("d2_head", out_data2, 32'h1);
        out_ready2 = 1;
        tick();
        chk("d2_pop1", out_data2, 32'h2);
        chk("d2_pop1_cnt", 32'(count2), 1);
        tick();
        in_valid2 = 0;
        chk("d2_pp", out_data2, 32'h3);
        chk("d2_pp_cnt", 32'(count2), 1);
        tick();
        chk("d2_empty", 32'(count2), 0);

        // Random traffic against a queue model
        q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            p_push = in_valid && (q.size() != 4);
            p_pop  = out_ready && (q.size() != 0);
            tick();
            if (p_pop) void'(q.pop_front());
            if (p_push) q.push_back(in_data);
            chk("rnd_count", 32'(count), 32'(q.size()));
            if (q.size() != 0) chk("rnd_data", out_data, q[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
